// File: rtl/ibex_bp_pkg.sv
// Shared definitions for the Ibex dynamic branch predictor.
//   - RV32I / RVC opcode and funct3 constants used by the fetch-stage decoder
//   - bp_class_e: decode classification of a fetched instruction
//   - bp_ctr_next(): saturating up/down counter update (counters up to 4 bits)
package ibex_bp_pkg;

    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    // Quadrant-01 RVC funct3 values (RV32 encoding: 001 is C.JAL)
    localparam logic [2:0] RVC_F3_JAL  = 3'b001;
    localparam logic [2:0] RVC_F3_J    = 3'b101;
    localparam logic [2:0] RVC_F3_BEQZ = 3'b110;
    localparam logic [2:0] RVC_F3_BNEZ = 3'b111;

    typedef enum logic [1:0] {
        BP_NONE,
        BP_JUMP,
        BP_COND
    } bp_class_e;

    // Counters are carried at the widest supported width; callers zero-extend
    // in and truncate out. ctr_max is the saturation ceiling for their width.
    function automatic logic [3:0] bp_ctr_next(input logic [3:0] ctr,
                                               input logic       taken,
                                               input logic [3:0] ctr_max);
        logic [3:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ctr_max) nxt = ctr + 4'd1;
        end else begin
            if (ctr != 4'd0) nxt = ctr - 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ibex_bp_decode.sv
// Combinational fetch-stage branch/jump decoder.
// Ports:
//   instr_i    : fetched word; compressed instructions occupy [15:0]
//   pc_i       : PC of instr_i
//   class_o    : BP_JUMP (JAL, C.J, C.JAL), BP_COND (Bxx, C.BEQZ, C.BNEZ), else BP_NONE
//   imm_neg_o  : sign of the branch/jump offset (backward target)
//   target_o   : pc_i + sign-extended offset, modulo 2^32; equals pc_i for BP_NONE
module ibex_bp_decode
    import ibex_bp_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output bp_class_e   class_o,
    output logic        imm_neg_o,
    output logic [31:0] target_o
);

    logic [31:0] imm;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        class_o = BP_NONE;
        imm     = 32'd0;

        if (instr_i[1:0] == 2'b11) begin
            if (instr_i[6:0] == OPCODE_JAL) begin
                class_o = BP_JUMP;
                imm     = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                           instr_i[30:21], 1'b0};
            end else if (instr_i[6:0] == OPCODE_BRANCH) begin
                class_o = BP_COND;
                imm     = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                           instr_i[11:8], 1'b0};
            end
        end else if (instr_i[1:0] == 2'b01) begin
            unique case (instr_i[15:13])
                RVC_F3_J, RVC_F3_JAL: begin
                    class_o = BP_JUMP;
                    imm     = {{21{instr_i[12]}}, instr_i[8], instr_i[10:9],
                               instr_i[6], instr_i[7], instr_i[2], instr_i[11],
                               instr_i[5:3], 1'b0};
                end
                RVC_F3_BEQZ, RVC_F3_BNEZ: begin
                    class_o = BP_COND;
                    imm     = {{24{instr_i[12]}}, instr_i[6:5], instr_i[2],
                               instr_i[11:10], instr_i[4:3], 1'b0};
                end
                default: ;
            endcase
        end
    end

    assign imm_neg_o = imm[31];
    assign target_o  = pc_i + imm;

endmodule

// File: rtl/ibex_branch_predict_bht.sv
// Dynamic branch predictor for the Ibex fetch stage.
// Jumps are predicted taken; conditional branches use a table of saturating
// counters indexed by PC (bimodal) or PC XOR global history (gshare), or a
// static backward-taken rule when DynamicEn=0. Training comes from ID/EX.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   fetch_rdata_i/pc_i/valid: instruction word being fetched
//   predict_branch_taken_o  : taken prediction (0 when invalid or in reset)
//   predict_branch_pc_o     : computed target
//   predict_idx_o           : table index, returned later on resolve_idx_i
//   resolve_valid_i/idx_i/taken_i : conditional branch outcome for training
module ibex_branch_predict_bht
    import ibex_bp_pkg::*;
#(
    parameter int unsigned NumEntries = 64,
    parameter int unsigned CtrW       = 2,
    parameter int unsigned HistLen    = 0,
    parameter bit          DynamicEn  = 1'b1,
    localparam int unsigned IdxW      = $clog2(NumEntries)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     fetch_rdata_i,
    input  logic [31:0]     fetch_pc_i,
    input  logic            fetch_valid_i,
    output logic            predict_branch_taken_o,
    output logic [31:0]     predict_branch_pc_o,
    output logic [IdxW-1:0] predict_idx_o,
    input  logic            resolve_valid_i,
    input  logic [IdxW-1:0] resolve_idx_i,
    input  logic            resolve_taken_i
);

    localparam logic [CtrW-1:0] CtrInit  = CtrW'((32'd1 << (CtrW - 1)) - 32'd1);
    localparam logic [3:0]      CtrMax   = 4'((32'd1 << CtrW) - 32'd1);
    // Only the low HistLen bits of the history register ever become non-zero.
    localparam logic [IdxW-1:0] HistMask = IdxW'((32'd1 << HistLen) - 32'd1);

    logic [CtrW-1:0] ctr_q [NumEntries];
    logic [IdxW-1:0] ghr_q;

    bp_class_e       br_class;
    logic            imm_neg;
    logic [IdxW-1:0] fetch_idx;
    logic            taken;

    ibex_bp_decode u_decode (
        .instr_i   (fetch_rdata_i),
        .pc_i      (fetch_pc_i),
        .class_o   (br_class),
        .imm_neg_o (imm_neg),
        .target_o  (predict_branch_pc_o)
    );

    // Halfword-aligned PC hashed with the registered (pre-update) history.
    assign fetch_idx     = fetch_pc_i[IdxW:1] ^ ghr_q;
    assign predict_idx_o = fetch_idx;

    always_comb begin
        taken = 1'b0;
        unique case (br_class)
            BP_JUMP: taken = 1'b1;
            BP_COND: taken = DynamicEn ? ctr_q[fetch_idx][CtrW-1] : imm_neg;
            default: taken = 1'b0;
        endcase
        if (!fetch_valid_i || rst_i) taken = 1'b0;
    end

    assign predict_branch_taken_o = taken;

    // NOTE: the counter table is a plain flop array, not a RAM macro, so every
    // entry can be loaded with its reset value on the same edge.
    // NOTE: state uses non-blocking assignments so the prediction path in this
    // cycle always reads the pre-update table and history.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumEntries; i++) begin
                ctr_q[i] <= CtrInit;
            end
            ghr_q <= '0;
        end else if (resolve_valid_i) begin
            ctr_q[resolve_idx_i] <= CtrW'(bp_ctr_next(4'(ctr_q[resolve_idx_i]),
                                                      resolve_taken_i, CtrMax));
            ghr_q <= {ghr_q[IdxW-2:0], resolve_taken_i} & HistMask;
        end
    end

endmodule

// File: tb/tb_ibex_branch_predict_bht.sv
// Self-checking bench for ibex_branch_predict_bht. Three instances share the
// stimulus: default bimodal, static (DynamicEn=0) and gshare (HistLen=4).
module tb_ibex_branch_predict_bht;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_rdata;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        resolve_valid;
    logic [5:0]  resolve_idx;
    logic        resolve_taken;

    logic        dyn_taken, st_taken, hs_taken;
    logic [31:0] dyn_pc, st_pc, hs_pc;
    logic [5:0]  dyn_idx, st_idx, hs_idx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ibex_branch_predict_bht u_dyn (
        .clk_i(clk), .rst_i(rst),
        .fetch_rdata_i(fetch_rdata), .fetch_pc_i(fetch_pc), .fetch_valid_i(fetch_valid),
        .predict_branch_taken_o(dyn_taken), .predict_branch_pc_o(dyn_pc),
        .predict_idx_o(dyn_idx),
        .resolve_valid_i(resolve_valid), .resolve_idx_i(resolve_idx),
        .resolve_taken_i(resolve_taken)
    );

    ibex_branch_predict_bht #(.DynamicEn(1'b0)) u_st (
        .clk_i(clk), .rst_i(rst),
        .fetch_rdata_i(fetch_rdata), .fetch_pc_i(fetch_pc), .fetch_valid_i(fetch_valid),
        .predict_branch_taken_o(st_taken), .predict_branch_pc_o(st_pc),
        .predict_idx_o(st_idx),
        .resolve_valid_i(resolve_valid), .resolve_idx_i(resolve_idx),
        .resolve_taken_i(resolve_taken)
    );

    ibex_branch_predict_bht #(.HistLen(4)) u_hs (
        .clk_i(clk), .rst_i(rst),
        .fetch_rdata_i(fetch_rdata), .fetch_pc_i(fetch_pc), .fetch_valid_i(fetch_valid),
        .predict_branch_taken_o(hs_taken), .predict_branch_pc_o(hs_pc),
        .predict_idx_o(hs_idx),
        .resolve_valid_i(resolve_valid), .resolve_idx_i(resolve_idx),
        .resolve_taken_i(resolve_taken)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] pc;
        logic        valid;
        logic        exp_dyn;
        logic        exp_st;
        logic        chk_pc;
        logic [31:0] exp_pc;
        logic [5:0]  exp_idx;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] rdata, input logic [31:0] pc, input logic v);
        fetch_rdata = rdata;
        fetch_pc    = pc;
        fetch_valid = v;
        #1;
    endtask

    task automatic resolve(input logic [5:0] idx, input logic tk);
        resolve_valid = 1'b1;
        resolve_idx   = idx;
        resolve_taken = tk;
        step();
        resolve_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] BEQ_M8  = 32'hFE000CE3; // beq x0,x0,-8
    localparam logic [31:0] JAL_P16 = 32'h0100006F; // jal x0,+16

    initial begin
        //            rdata          pc           v     dyn   st    chkpc exp_pc        idx
        vecs[0] = '{BEQ_M8,        32'h00000100, 1'b1, 1'b0, 1'b1, 1'b1, 32'h000000F8, 6'h00};
        vecs[1] = '{JAL_P16,       32'h00000200, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000210, 6'h00};
        vecs[2] = '{JAL_P16,       32'h00000200, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000210, 6'h00};
        vecs[3] = '{32'hABCDDC75,  32'h00000002, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFE, 6'h01}; // c.beqz -4
        vecs[4] = '{32'h0000A021,  32'h00000010, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000018, 6'h08}; // c.j +8
        vecs[5] = '{32'h00003FFD,  32'h00000020, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000001E, 6'h10}; // c.jal -2
        vecs[6] = '{32'h00209663,  32'h00000300, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000030C, 6'h00}; // bne +12
        vecs[7] = '{32'h00008082,  32'h00000040, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 6'h20}; // c.jr
        vecs[8] = '{32'h00008067,  32'h00000044, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 6'h22}; // jalr
        vecs[9] = '{32'h0000E011,  32'h0000007E, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000082, 6'h3F}; // c.bnez +4

        rst           = 1'b1;
        resolve_valid = 1'b0;
        resolve_idx   = '0;
        resolve_taken = 1'b0;
        fetch(JAL_P16, 32'h200, 1'b1);

        // Reset forces the prediction low even for a valid jump.
        step();
        check("reset_forces_not_taken", 32'(dyn_taken), 32'd0);
        step();
        rst = 1'b0;
        #1;

        // Decode table against freshly reset counters (weakly not-taken).
        for (int i = 0; i < 10; i++) begin
            fetch(vecs[i].rdata, vecs[i].pc, vecs[i].valid);
            check($sformatf("vec%0d_dyn_taken", i), 32'(dyn_taken), 32'(vecs[i].exp_dyn));
            check($sformatf("vec%0d_static_taken", i), 32'(st_taken), 32'(vecs[i].exp_st));
            check($sformatf("vec%0d_idx", i), 32'(dyn_idx), 32'(vecs[i].exp_idx));
            if (vecs[i].chk_pc)
                check($sformatf("vec%0d_target", i), dyn_pc, vecs[i].exp_pc);
        end

        // Counter training and saturation at idx 0.
        fetch(BEQ_M8, 32'h100, 1'b1);
        resolve(6'd0, 1'b1);
        check("train_t1_taken", 32'(dyn_taken), 32'd1);
        resolve(6'd0, 1'b1);
        check("train_t2_taken", 32'(dyn_taken), 32'd1);
        for (int i = 0; i < 10; i++) resolve(6'd0, 1'b1);
        check("saturate_high_taken", 32'(dyn_taken), 32'd1);
        resolve(6'd0, 1'b0);
        check("after_nt1_taken", 32'(dyn_taken), 32'd1);
        resolve(6'd0, 1'b0);
        check("after_nt2_not_taken", 32'(dyn_taken), 32'd0);
        check("static_ignores_table", 32'(st_taken), 32'd1);

        // Jump prediction does not depend on the trained table.
        fetch(JAL_P16, 32'h200, 1'b1);
        check("jal_after_training", 32'(dyn_taken), 32'd1);

        // Same-cycle fetch and resolve at idx 0: old counter (1) is used.
        fetch(BEQ_M8, 32'h100, 1'b1);
        resolve_valid = 1'b1;
        resolve_idx   = 6'd0;
        resolve_taken = 1'b1;
        #1;
        check("same_cycle_old_value", 32'(dyn_taken), 32'd0);
        step();
        resolve_valid = 1'b0;
        check("next_cycle_new_value", 32'(dyn_taken), 32'd1);
        // gshare history: last four outcomes T,N,N,T -> 4'b1001.
        check("gshare_hist_idx", 32'(hs_idx), 32'h09);

        // Reset with a resolve pending: update dropped, everything reinitialised.
        rst           = 1'b1;
        resolve_valid = 1'b1;
        resolve_idx   = 6'd0;
        resolve_taken = 1'b1;
        step();
        rst           = 1'b0;
        resolve_valid = 1'b0;
        #1;
        check("reset_ctr_not_taken", 32'(dyn_taken), 32'd0);
        check("reset_ghr_idx", 32'(hs_idx), 32'h00);
        resolve(6'd0, 1'b1);
        check("reset_ctr_is_one_up", 32'(dyn_taken), 32'd1);
        resolve(6'd0, 1'b0);
        check("reset_ctr_is_one_down", 32'(dyn_taken), 32'd0);

        // gshare: train idx 7 while building history 0111.
        pulse_reset();
        resolve(6'd7, 1'b1);
        resolve(6'd7, 1'b1);
        resolve(6'd20, 1'b1);
        fetch(BEQ_M8, 32'h100, 1'b1);
        check("gshare_idx_0111", 32'(hs_idx), 32'h07);
        check("gshare_taken", 32'(hs_taken), 32'd1);
        check("bimodal_idx", 32'(dyn_idx), 32'h00);
        check("bimodal_not_taken", 32'(dyn_taken), 32'd0);
        for (int i = 0; i < 4; i++) resolve(6'd30, 1'b0);
        check("gshare_idx_cleared", 32'(hs_idx), 32'h00);
        check("gshare_zero_hist_not_taken", 32'(hs_taken), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_branch_predict_bht.md
# ibex_branch_predict_bht

Parametrised dynamic branch predictor for the Ibex prefetch/fetch stage. It replaces the purely static predictor. Each instruction word presented at fetch is decoded for RV32I/RVC branches and jumps. Jumps are always predicted taken. Conditional branches are predicted from a table of saturating counters, indexed by PC or by PC XOR global history (gshare). Counters and history are trained non-speculatively from branch resolution in the ID/EX stage.

## Interface
Parameters:
- `NumEntries`, 64: number of counters; power of two, ≥ 4; `IdxW = $clog2(NumEntries)`.
- `CtrW`, 2: counter width, 1..4.
- `HistLen`, 0: global history bits, 0..IdxW; 0 selects pure bimodal indexing.
- `DynamicEn`, 1'b1: 0 bypasses the table and predicts conditional branches with static backward-taken/forward-not-taken.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `fetch_rdata_i` in 32: fetched instruction; compressed instructions sit in bits [15:0].
- `fetch_pc_i` in 32: PC of `fetch_rdata_i`.
- `fetch_valid_i` in 1: fetch data valid.
- `predict_branch_taken_o` out 1: predict taken.
- `predict_branch_pc_o` out 32: predicted target.
- `predict_idx_o` out IdxW: table index used; carried down the pipeline to `resolve_idx_i`.
- `resolve_valid_i` in 1: a conditional branch resolved this cycle.
- `resolve_idx_i` in IdxW: index returned with the resolved branch.
- `resolve_taken_i` in 1: actual outcome.

## Operation
- Decode detects the following, from opcode/funct only:
  - JAL (opcode 1101111) and conditional branch (1100011) when `fetch_rdata_i[1:0]==2'b11`.
  - C.J, C.JAL, C.BEQZ, C.BNEZ (quadrant 01) otherwise.
  - JALR and C.JR/C.JALR are never predicted.
- Target = `fetch_pc_i` + sign-extended immediate (B, J, CB or CJ format), computed modulo 2^32.
- Index = `fetch_pc_i[IdxW:1]` XOR {zeros, `ghr[HistLen-1:0]`}. Index is output even for non-branches.
- Taken decision:
  - Jump: 1.
  - Conditional branch with DynamicEn=1: counter[idx] MSB.
  - Conditional branch with DynamicEn=0: immediate sign bit.
  - Any other instruction: 0.
  - `predict_branch_taken_o` is forced to 0 when `fetch_valid_i`=0 or `rst_i`=1.
- `predict_branch_pc_o` always shows the computed target. It is don't-care when not taken, but deterministic.
- Training, on `resolve_valid_i`=1:
  - counter[`resolve_idx_i`] increments if taken, else decrements.
  - It saturates at 0 and 2^CtrW−1.
  - GHR shifts left, inserting `resolve_taken_i` at bit 0, when HistLen>0.
- Reset: every counter is set to 2^(CtrW−1)−1 (weakly not-taken; 01 for CtrW=2). GHR is set to 0. `resolve_valid_i` is ignored while `rst_i`=1.
- With DynamicEn=0, the table and GHR are still present but unused. Synthesis removes them.

## Timing
- Prediction is combinational: outputs are a function of the fetch inputs and the registered table/GHR in the same cycle. There is no handshake.
- Update latency is one cycle. A write on edge N is visible to predictions from cycle N+1.
- Same-cycle read and write to the same index: the prediction uses the pre-update value, with no bypass.
- Same-cycle resolve and GHR shift: the fetch index uses the old GHR.
- Multiple resolves cannot occur; only one resolve port exists.
- Reset asserted mid-training discards the update of that cycle and reinitialises everything at the next edge.
- Counter state is table-of-flops only, with no SRAM. Any number of entries can be reset in a single edge.

## Structure
- Shared package `ibex_bp_pkg` holds:
  - Opcode constants (`OPCODE_BRANCH`, `OPCODE_JAL`).
  - RVC funct3 constants.
  - `typedef enum {BP_NONE, BP_JUMP, BP_COND}` for the decode class.
  - Function `bp_ctr_next(ctr, taken)` implementing saturating update.
- One sub-module is natural: `ibex_bp_decode`. It is purely combinational (instruction → class, immediate, target).
- The top holds the counter array, GHR, index hash and taken mux.

## Test plan
- Reset with defaults; `fetch_pc_i`=0x100, `fetch_rdata_i`=0xFE000CE3 (beq x0,x0,−8), valid=1 → taken=0, pc_o=0x000000F8, idx_o=0.
- Resolve idx 0 taken twice, then refetch the same instruction → taken=1 after the second update. Ten further taken resolves → counter stays 3. Two not-taken resolves → taken=0.
- `fetch_rdata_i`=0x0100006F (jal x0,+16) at pc 0x200 → taken=1, pc_o=0x210, independent of table state. Same input with valid=0 → taken=0.
- C.BEQZ with negative offset at pc 0x0000_0002 under DynamicEn=0 → taken=1, target wraps correctly modulo 2^32. Under DynamicEn=1 just after reset → taken=0.
- HistLen=4: resolve taken ×3 (GHR=0111), then fetch pc 0x100 → idx_o=0x07. Train that idx to taken and confirm that fetch predicts taken while pc 0x100 with GHR=0 does not.
- Resolve taken at idx 0 in the same cycle as a fetch at idx 0 → that cycle uses the old counter value. Assert `rst_i` with `resolve_valid_i`=1 → all counters return to 1 and GHR to 0.
